tdm_demux4: RTL and testbench
=============================

// Module: tdm_demux4
// PURPOSE
//   Receive end of the 4-channel time-division link: takes one WIDTH-bit word per
//   valid beat and steers beats 0..3 of each frame into four channel registers.
//   Commits a full frame atomically and pulses frame_valid. Sits between the
//   serial link and the per-channel consumers (LEDR/HEX display logic).
// PARAMETERS
//   WIDTH   4   bits per channel word
// PORTS
//   clock        in   1         system clock, all logic on rising edge
//   resetn       in   1         asynchronous, active-low reset
//   din          in   WIDTH     link data word
//   din_valid    in   1         din/sof carry a beat this cycle
//   sof          in   1         start-of-frame; qualifies beat as slot 0
//   din_par      in   1         even-parity bit for din (only with TDM_PARITY_EN)
//   ch_out       out  4*WIDTH   committed frame; ch_out[WIDTH*k +: WIDTH] = slot k
//   frame_valid  out  1         1-cycle pulse: ch_out just updated
//   frame_err    out  1         1-cycle pulse: framing/parity fault, frame dropped
//   slot         out  2         next slot expected (0..3)
// BEHAVIOUR
//   - Reset (async, resetn=0): state=HUNT, slot=0, shadow regs=0, ch_out=0,
//     frame_valid=0, frame_err=0. Reset mid-frame discards partial frame.
//   - Cycles with din_valid=0: nothing changes; pulses deassert.
//   - HUNT: beat with sof=1 -> shadow[0]<=din, slot<=1, go COLLECT.
//     Beat with sof=0 -> ignored, no error (link not yet aligned).
//   - COLLECT, slot=0: sof=1 -> shadow[0]<=din, slot<=1. sof=0 -> frame_err
//     pulse, slot<=0, go HUNT.
//   - COLLECT, slot=1..2: sof=0 -> shadow[slot]<=din, slot++. sof=1 ->
//     frame_err pulse, partial frame discarded, beat taken as new slot 0
//     (shadow[0]<=din, slot<=1).
//   - COLLECT, slot=3: sof=0 -> ch_out<={din,shadow[2],shadow[1],shadow[0]},
//     frame_valid pulse, slot<=0 (wrap), stay COLLECT. sof=1 -> as slot 1..2 case.
//   - Latency: ch_out/frame_valid visible the cycle after the edge capturing beat 3.
//     ch_out holds between commits; partial frames never reach ch_out.
//   - frame_valid and frame_err never both 1 in the same cycle.
//   - Back-to-back beats every cycle supported; throughput 1 frame per 4 beats.
// CONFIGURATION
//   TDM_PARITY_EN defined: din_par port present; beat bad if ^{din,din_par}=1.
//     Bad beat marks current frame bad; at slot-3 commit a bad frame gives
//     frame_err instead of frame_valid and ch_out is not updated; state stays
//     COLLECT. Bad flag clears on every slot-0 beat and on reset.
//   TDM_PARITY_EN undefined: din_par port absent, no parity logic, no check.
// STRUCTURE
//   tdm_pkg: NCH=4, SLOT_W=2, state localparams TDM_HUNT/TDM_COLLECT.
//   Sub-module demux1to4_dec: slot[1:0] + en -> one-hot shadow write enables
//   (combinational inverse of the team's 4-to-1 mux). Top holds FSM, slot
//   counter, shadow regs, commit regs.
// TESTING (WIDTH=4)
//   1. Reset, then beats sof=1 din=1, din=2,3,4 -> next cycle ch_out=16'h4321,
//      frame_valid=1 for one cycle, slot=0.
//   2. Beats din=5,6 (sof=0) in HUNT -> ignored, no err; then sof=1 frame 9,A,B,C
//      -> ch_out=16'hCBA9.
//   3. After good frame, sof=1 din=1, din=2, sof=1 din=7, din=8,9,A -> frame_err
//      pulse at 2nd sof, then ch_out=16'hA987.
//   4. In COLLECT slot 0, beat sof=0 din=F -> frame_err pulse, state HUNT,
//      ch_out unchanged.
//   5. resetn low after 2 beats, release, send frame 1..4 -> ch_out=16'h4321,
//      no stale data; outputs 0 while resetn=0 (asynchronously).
//   6. TDM_PARITY_EN: frame 1,2,3,4 with bad parity on beat 2 -> frame_err,
//      ch_out unchanged; next good frame commits normally.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the 4-channel TDM receive path.
package tdm_pkg;

   localparam int unsigned NCH    = 4;
   localparam int unsigned SLOT_W = 2;

   typedef enum logic {
      TDM_HUNT    = 1'b0,
      TDM_COLLECT = 1'b1
   } tdm_state_e;

   localparam logic [SLOT_W-1:0] SLOT_FIRST = SLOT_W'(0);
   localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NCH - 1);

endpackage

// File: rtl/demux1to4_dec.sv
// Slot index plus enable to one-hot write strobes for the per-slot registers.
module demux1to4_dec
   import tdm_pkg::*;
(
   input  logic [SLOT_W-1:0] sel,
   input  logic              en,
   output logic [NCH-1:0]    we_c
);

   always_comb begin
      we_c = '0;
      if (en) we_c[sel] = 1'b1;
   end

endmodule

// File: rtl/tdm_demux4.sv
// TDM link receiver: aligns on sof, gathers four slot words, commits whole frames.
// Optional even-parity checking is built when TDM_PARITY_EN is defined.
module tdm_demux4
   import tdm_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                   clock,
   input  logic                   resetn,
   input  logic [WIDTH-1:0]       din,
   input  logic                   din_valid,
   input  logic                   sof,
`ifdef TDM_PARITY_EN
   input  logic                   din_par,
`endif
   output logic [NCH*WIDTH-1:0]   ch_out,
   output logic                   frame_valid,
   output logic                   frame_err,
   output logic [SLOT_W-1:0]      slot
);

   tdm_state_e                    state, state_n;
   logic [SLOT_W-1:0]             slot_n;
   logic                          fv_n, fe_n;
   logic                          wr_en;
   logic [SLOT_W-1:0]             wr_slot;
   logic [NCH-1:0]                we_c;
   logic [NCH-2:0][WIDTH-1:0]     shadow;
   logic                          frame_bad_c;

`ifdef TDM_PARITY_EN
   logic bad_q;
   logic beat_bad_c;

   assign beat_bad_c  = ^{din, din_par};
   assign frame_bad_c = bad_q | beat_bad_c;

   // A slot-0 beat restarts the flag; later beats of the frame accumulate into it.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         bad_q <= 1'b0;
      end else if (din_valid) begin
         if (sof)
            bad_q <= beat_bad_c;
         else if (state == TDM_COLLECT && slot != SLOT_FIRST)
            bad_q <= frame_bad_c;
      end
   end
`else
   assign frame_bad_c = 1'b0;
`endif

   // State, slot counter and status pulses.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= TDM_HUNT;
         slot        <= SLOT_FIRST;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_n;
         slot        <= slot_n;
         frame_valid <= fv_n;
         frame_err   <= fe_n;
      end
   end

   always_comb begin
      state_n = state;
      slot_n  = slot;
      fv_n    = 1'b0;
      fe_n    = 1'b0;
      wr_en   = 1'b0;
      wr_slot = slot;

      if (din_valid) begin
         unique case (state)
            TDM_HUNT: begin
               if (sof) begin
                  wr_en   = 1'b1;
                  wr_slot = SLOT_FIRST;
                  slot_n  = SLOT_W'(1);
                  state_n = TDM_COLLECT;
               end
            end
            TDM_COLLECT: begin
               if (sof) begin
                  // sof anywhere but slot 0 aborts the partial frame and resyncs on this beat
                  fe_n    = (slot != SLOT_FIRST);
                  wr_en   = 1'b1;
                  wr_slot = SLOT_FIRST;
                  slot_n  = SLOT_W'(1);
               end else if (slot == SLOT_FIRST) begin
                  fe_n    = 1'b1;
                  slot_n  = SLOT_FIRST;
                  state_n = TDM_HUNT;
               end else if (slot == SLOT_LAST) begin
                  wr_en   = !frame_bad_c;
                  wr_slot = SLOT_LAST;
                  fv_n    = !frame_bad_c;
                  fe_n    = frame_bad_c;
                  slot_n  = SLOT_FIRST;
               end else begin
                  wr_en   = 1'b1;
                  slot_n  = slot + SLOT_W'(1);
               end
            end
            default: begin
               state_n = TDM_HUNT;
               slot_n  = SLOT_FIRST;
            end
         endcase
      end
   end

   demux1to4_dec u_dec (
      .sel  (wr_slot),
      .en   (wr_en),
      .we_c (we_c)
   );

   // Slots 0..2 stage in shadow; slot 3 goes straight into the commit register.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         shadow <= '0;
         ch_out <= '0;
      end else begin
         for (int k = 0; k < NCH - 1; k++) begin
            if (we_c[k]) shadow[k] <= din;
         end
         if (we_c[NCH-1]) ch_out <= {din, shadow[2], shadow[1], shadow[0]};
      end
   end

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed self-checking bench for tdm_demux4 (WIDTH=4); parity test under TDM_PARITY_EN.
module tb_tdm_demux4;

   logic        clock;
   logic        resetn;
   logic [3:0]  din;
   logic        din_valid;
   logic        sof;
`ifdef TDM_PARITY_EN
   logic        din_par;
`endif
   logic [15:0] ch_out;
   logic        frame_valid;
   logic        frame_err;
   logic [1:0]  slot;

   int total = 0;
   int bad   = 0;

   tdm_demux4 #(.WIDTH(4)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .din         (din),
      .din_valid   (din_valid),
      .sof         (sof),
`ifdef TDM_PARITY_EN
      .din_par     (din_par),
`endif
      .ch_out      (ch_out),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .slot        (slot)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One beat driven at negedge; returns 1 time unit after the capturing edge.
   task automatic send(input logic s, input logic [3:0] d, input logic par_flip);
      @(negedge clock);
      din_valid = 1'b1;
      sof       = s;
      din       = d;
`ifdef TDM_PARITY_EN
      din_par   = (^d) ^ par_flip;
`else
      if (par_flip) din_valid = 1'b1;
`endif
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      @(negedge clock);
      din_valid = 1'b0;
      sof       = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      din_valid = 1'b0;
      sof       = 1'b0;
      resetn    = 1'b0;
      @(negedge clock);
      resetn    = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      total++; if (ch_out !== 16'h0000) begin bad++; $display("FAIL reset_ch_out got=%h want=0000", ch_out); end
      total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv got=%b want=0", frame_valid); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b want=0", frame_err); end
      total++; if (slot !== 2'd0) begin bad++; $display("FAIL reset_slot got=%0d want=0", slot); end
   endtask

   task automatic test_basic_frame();
      send(1'b1, 4'h1, 1'b0);
      total++; if (slot !== 2'd1) begin bad++; $display("FAIL basic_slot1 got=%0d want=1", slot); end
      send(1'b0, 4'h2, 1'b0);
      send(1'b0, 4'h3, 1'b0);
      total++; if (ch_out !== 16'h0000) begin bad++; $display("FAIL basic_partial got=%h want=0000", ch_out); end
      send(1'b0, 4'h4, 1'b0);
      total++; if (ch_out !== 16'h4321) begin bad++; $display("FAIL basic_ch_out got=%h want=4321", ch_out); end
      total++; if (frame_valid !== 1'b1) begin bad++; $display("FAIL basic_fv got=%b want=1", frame_valid); end
      total++; if (slot !== 2'd0) begin bad++; $display("FAIL basic_slot_wrap got=%0d want=0", slot); end
      idle();
      total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL basic_fv_pulse got=%b want=0", frame_valid); end
      total++; if (ch_out !== 16'h4321) begin bad++; $display("FAIL basic_hold got=%h want=4321", ch_out); end
   endtask

   task automatic test_hunt();
      do_reset();
      send(1'b0, 4'h5, 1'b0);
      total++; if (frame_err !== 1'b0 || slot !== 2'd0) begin bad++; $display("FAIL hunt_ignore5 got fe=%b slot=%0d want fe=0 slot=0", frame_err, slot); end
      send(1'b0, 4'h6, 1'b0);
      total++; if (frame_err !== 1'b0 || slot !== 2'd0) begin bad++; $display("FAIL hunt_ignore6 got fe=%b slot=%0d want fe=0 slot=0", frame_err, slot); end
      send(1'b1, 4'h9, 1'b0);
      send(1'b0, 4'hA, 1'b0);
      send(1'b0, 4'hB, 1'b0);
      send(1'b0, 4'hC, 1'b0);
      total++; if (ch_out !== 16'hCBA9 || frame_valid !== 1'b1) begin bad++; $display("FAIL hunt_frame got=%h fv=%b want=CBA9 fv=1", ch_out, frame_valid); end
   endtask

   task automatic test_resync();
      send(1'b1, 4'h1, 1'b0);
      send(1'b0, 4'h2, 1'b0);
      send(1'b1, 4'h7, 1'b0);
      total++; if (frame_err !== 1'b1 || frame_valid !== 1'b0) begin bad++; $display("FAIL resync_err got fe=%b fv=%b want fe=1 fv=0", frame_err, frame_valid); end
      total++; if (slot !== 2'd1 || ch_out !== 16'hCBA9) begin bad++; $display("FAIL resync_state got slot=%0d ch=%h want slot=1 ch=CBA9", slot, ch_out); end
      send(1'b0, 4'h8, 1'b0);
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL resync_err_pulse got=%b want=0", frame_err); end
      send(1'b0, 4'h9, 1'b0);
      send(1'b0, 4'hA, 1'b0);
      total++; if (ch_out !== 16'hA987 || frame_valid !== 1'b1) begin bad++; $display("FAIL resync_frame got=%h fv=%b want=A987 fv=1", ch_out, frame_valid); end
   endtask

   task automatic test_slot0_err();
      send(1'b0, 4'hF, 1'b0);
      total++; if (frame_err !== 1'b1 || frame_valid !== 1'b0) begin bad++; $display("FAIL s0err_pulse got fe=%b fv=%b want fe=1 fv=0", frame_err, frame_valid); end
      total++; if (slot !== 2'd0 || ch_out !== 16'hA987) begin bad++; $display("FAIL s0err_state got slot=%0d ch=%h want slot=0 ch=A987", slot, ch_out); end
      send(1'b0, 4'h3, 1'b0);
      total++; if (frame_err !== 1'b0 || slot !== 2'd0) begin bad++; $display("FAIL s0err_hunt got fe=%b slot=%0d want fe=0 slot=0", frame_err, slot); end
   endtask

   task automatic test_reset_midframe();
      send(1'b1, 4'hE, 1'b0);
      send(1'b0, 4'hD, 1'b0);
      @(negedge clock);
      din_valid = 1'b0;
      resetn    = 1'b0;
      #1;
      total++; if (ch_out !== 16'h0000 || slot !== 2'd0) begin bad++; $display("FAIL async_reset got ch=%h slot=%0d want ch=0000 slot=0", ch_out, slot); end
      @(negedge clock);
      resetn = 1'b1;
      send(1'b1, 4'h1, 1'b0);
      send(1'b0, 4'h2, 1'b0);
      send(1'b0, 4'h3, 1'b0);
      send(1'b0, 4'h4, 1'b0);
      total++; if (ch_out !== 16'h4321 || frame_valid !== 1'b1) begin bad++; $display("FAIL rst_frame got=%h fv=%b want=4321 fv=1", ch_out, frame_valid); end
   endtask

   task automatic test_back_to_back();
      send(1'b1, 4'h5, 1'b0);
      total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL b2b_fv_drop got=%b want=0", frame_valid); end
      send(1'b0, 4'h6, 1'b0);
      send(1'b0, 4'h7, 1'b0);
      send(1'b0, 4'h8, 1'b0);
      total++; if (ch_out !== 16'h8765 || frame_valid !== 1'b1) begin bad++; $display("FAIL b2b_frame1 got=%h fv=%b want=8765 fv=1", ch_out, frame_valid); end
      send(1'b1, 4'hD, 1'b0);
      send(1'b0, 4'hE, 1'b0);
      send(1'b0, 4'hF, 1'b0);
      send(1'b0, 4'h0, 1'b0);
      total++; if (ch_out !== 16'h0FED || frame_valid !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL b2b_frame2 got=%h fv=%b fe=%b want=0FED fv=1 fe=0", ch_out, frame_valid, frame_err); end
   endtask

`ifdef TDM_PARITY_EN
   task automatic test_parity();
      send(1'b1, 4'h1, 1'b0);
      send(1'b0, 4'h2, 1'b1);
      send(1'b0, 4'h3, 1'b0);
      send(1'b0, 4'h4, 1'b0);
      total++; if (frame_err !== 1'b1 || frame_valid !== 1'b0) begin bad++; $display("FAIL par_err got fe=%b fv=%b want fe=1 fv=0", frame_err, frame_valid); end
      total++; if (ch_out !== 16'h0FED || slot !== 2'd0) begin bad++; $display("FAIL par_hold got ch=%h slot=%0d want ch=0FED slot=0", ch_out, slot); end
      send(1'b1, 4'h9, 1'b0);
      send(1'b0, 4'hA, 1'b0);
      send(1'b0, 4'hB, 1'b0);
      send(1'b0, 4'hC, 1'b0);
      total++; if (ch_out !== 16'hCBA9 || frame_valid !== 1'b1 || frame_err !== 1'b0) begin bad++; $display("FAIL par_recover got=%h fv=%b fe=%b want=CBA9 fv=1 fe=0", ch_out, frame_valid, frame_err); end
   endtask
`endif

   initial begin
      resetn    = 1'b0;
      din       = 4'h0;
      din_valid = 1'b0;
      sof       = 1'b0;
`ifdef TDM_PARITY_EN
      din_par   = 1'b0;
`endif
      test_reset();
      test_basic_frame();
      test_hunt();
      test_resync();
      test_slot0_err();
      test_reset_midframe();
      test_back_to_back();
`ifdef TDM_PARITY_EN
      test_parity();
`endif
      idle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
